// File: rtl/uart_rx_ctrl_if.sv
// Host-side receive FIFO bus: consumer pops bytes and watches the flags.
interface uart_rx_ctrl_if #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 2
);
  logic              rd_en;
  logic [DBIT-1:0]   rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              ovr_clr;

  modport master (output rd_en, ovr_clr, input rd_data, empty, full, count, overrun);
  modport slave  (input rd_en, ovr_clr, output rd_data, empty, full, count, overrun);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver wrapper: baud tick, line conditioning, core gating, FWFT receive FIFO.
// Optional macro UART_RX_GLITCH_FILTER_EN adds a 2-of-3 majority filter on rx_sync.
module uart_rx_ctrl #(
  parameter int DBIT       = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              rx_in,
  output logic              rx_sync,
  output logic              s_tick,
  output logic              rx_core_rst_n,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout,
  uart_rx_ctrl_if.slave     host
);

  // ---- line synchronizer ----
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};

  // ---- core gating ----
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_core_rst_n <= 1'b0;
    else        rx_core_rst_n <= rx_en;

  // ---- baud generator; >= keeps it bounded when baud_div drops below the count ----
  logic [DIV_W-1:0] div_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      s_tick  <= 1'b0;
    end else if (!rx_en) begin
      div_cnt <= '0;
      s_tick  <= 1'b0;
    end else if (div_cnt >= baud_div) begin
      div_cnt <= '0;
      s_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      s_tick  <= 1'b0;
    end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [2:0] flt_sh;
  logic       flt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flt_sh <= 3'b111;
      flt_q  <= 1'b1;
    end else begin
      if (!rx_en)      flt_sh <= 3'b111;
      else if (s_tick) flt_sh <= {flt_sh[1:0], sync_q[1]};
      flt_q <= (flt_sh[0] & flt_sh[1]) | (flt_sh[0] & flt_sh[2]) | (flt_sh[1] & flt_sh[2]);
    end
  assign rx_sync = flt_q;
`else
  assign rx_sync = sync_q[1];
`endif

  // ---- receive FIFO ----
  logic [DBIT-1:0]   mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              push, pop, wr_ok, drop;

  assign host.empty   = (cnt == '0);
  assign host.full    = (cnt == (ADDR_W+1)'(FIFO_DEPTH));
  assign host.count   = cnt;
  assign host.rd_data = mem[rd_ptr];

  assign push  = rx_done_tick & rx_en;
  assign pop   = host.rd_en & ~host.empty;
  // When full, a same-cycle pop frees the head slot the write lands in.
  assign wr_ok = push & (~host.full | pop);
  assign drop  = push & host.full & ~pop;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= rx_dout;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_ok && !pop)      cnt <= cnt + (ADDR_W+1)'(1);
      else if (pop && !wr_ok) cnt <= cnt - (ADDR_W+1)'(1);
    end

  // Drop wins over clear so a byte lost during the clear is still reported.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            host.overrun <= 1'b0;
    else if (drop)         host.overrun <= 1'b1;
    else if (host.ovr_clr) host.overrun <= 1'b0;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud tick, FIFO ordering/flags, overrun, enable gating, rx_sync.
module tb_uart_rx_ctrl;
  localparam int DBIT = 8, DIV_W = 16, DEPTH = 4, AW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_en = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             rx_in = 1'b1;
  logic             rx_sync, s_tick, rx_core_rst_n;
  logic             rx_done_tick = 1'b0;
  logic [DBIT-1:0]  rx_dout = '0;

  int total = 0, bad = 0;

  uart_rx_ctrl_if #(.DBIT(DBIT), .ADDR_W(AW)) hif ();

  uart_rx_ctrl #(.DBIT(DBIT), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_div(baud_div),
    .rx_in(rx_in), .rx_sync(rx_sync), .s_tick(s_tick), .rx_core_rst_n(rx_core_rst_n),
    .rx_done_tick(rx_done_tick), .rx_dout(rx_dout), .host(hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin step(); n++; end while (!s_tick && n < 64);
  endtask

  task automatic push(input logic [7:0] d);
    rx_dout = d; rx_done_tick = 1'b1; step(); rx_done_tick = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, hif.rd_data, exp);
    hif.rd_en = 1'b1; step(); hif.rd_en = 1'b0;
  endtask

  initial begin
    int n, lows, first_low;
    hif.rd_en = 1'b0; hif.ovr_clr = 1'b0;
    #12;
    chk("rst_empty", hif.empty, 1); chk("rst_full", hif.full, 0);
    chk("rst_count", hif.count, 0); chk("rst_ovr", hif.overrun, 0);
    chk("rst_rddata", hif.rd_data, 0); chk("rst_rxsync", rx_sync, 1);
    chk("rst_stick", s_tick, 0); chk("rst_corerst", rx_core_rst_n, 0);
    step(); rst_n = 1'b1; step();

    // baud generator
    baud_div = 9; rx_en = 1'b1;
    wait_tick(n); chk("first_tick", n, 10);
    step(); chk("tick_width", s_tick, 0);
    chk("core_rst_rel", rx_core_rst_n, 1);
    repeat (6) step();
    baud_div = 3;
    step(); chk("tick_after_lower", s_tick, 1);
    wait_tick(n); chk("period4_a", n, 4);
    wait_tick(n); chk("period4_b", n, 4);

    // fill, overrun, drain in order
    push(8'hA5); push(8'h3C); push(8'hFF); push(8'h01);
    chk("full", hif.full, 1); chk("count4", hif.count, 4); chk("head", hif.rd_data, 8'hA5);
    push(8'h77);
    chk("ovr_set", hif.overrun, 1); chk("ovr_count", hif.count, 4); chk("ovr_head", hif.rd_data, 8'hA5);
    pop("d0", 8'hA5); pop("d1", 8'h3C); pop("d2", 8'hFF); pop("d3", 8'h01);
    chk("drained", hif.empty, 1);
    hif.rd_en = 1'b1; step(); hif.rd_en = 1'b0;
    chk("pop_empty_cnt", hif.count, 0);

    // clear vs drop priority
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    hif.ovr_clr = 1'b1; push(8'h66); hif.ovr_clr = 1'b0;
    chk("clr_vs_drop", hif.overrun, 1);
    hif.ovr_clr = 1'b1; step(); hif.ovr_clr = 1'b0;
    chk("clr_alone", hif.overrun, 0);

    // push+pop when full
    hif.rd_en = 1'b1; push(8'h55); hif.rd_en = 1'b0;
    chk("pp_full_cnt", hif.count, 4); chk("pp_full_ovr", hif.overrun, 0);
    pop("f0", 8'h22); pop("f1", 8'h33); pop("f2", 8'h44); pop("f3", 8'h55);
    // push+pop when empty
    hif.rd_en = 1'b1; push(8'h55); hif.rd_en = 1'b0;
    chk("pp_empty_cnt", hif.count, 1); chk("pp_empty_data", hif.rd_data, 8'h55);
    pop("e0", 8'h55);

    // reset mid-operation: 2 queued, overrun set
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    pop("m0", 8'h01); pop("m1", 8'h02);
    chk("pre_rst_cnt", hif.count, 2); chk("pre_rst_ovr", hif.overrun, 1);
    #3 rst_n = 1'b0; #1;
    chk("arst_cnt", hif.count, 0); chk("arst_empty", hif.empty, 1);
    chk("arst_ovr", hif.overrun, 0); chk("arst_data", hif.rd_data, 0);
    chk("arst_corerst", rx_core_rst_n, 0); chk("arst_stick", s_tick, 0);
    chk("arst_rxsync", rx_sync, 1);
    step(); rst_n = 1'b1; step();
    chk("post_rst_empty", hif.empty, 1); chk("post_rst_cnt", hif.count, 0);

    // one-tick-period low on the line
    baud_div = 3;
    rx_in = 1'b0; lows = 0; first_low = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 5) rx_in = 1'b1;
      step();
      if (!rx_sync) begin lows++; if (first_low == 0) first_low = i; end
    end
`ifdef UART_RX_GLITCH_FILTER_EN
    chk("glitch_lows", lows, 0);
`else
    chk("glitch_first_low", first_low, 2);
    chk("glitch_lows", lows, 4);
`endif

    // disable mid-frame
    push(8'h9A); push(8'hBC);
    rx_en = 1'b0; step();
    chk("dis_corerst", rx_core_rst_n, 0); chk("dis_stick", s_tick, 0);
    push(8'hEE);
    chk("dis_ignored", hif.count, 2); chk("dis_head", hif.rd_data, 8'h9A);
    lows = 0;
    for (int i = 0; i < 8; i++) begin step(); if (s_tick) lows++; end
    chk("dis_no_ticks", lows, 0);
    rx_en = 1'b1;
    wait_tick(n); chk("reen_tick", n, 4);
    pop("r0", 8'h9A); pop("r1", 8'hBC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
